run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter SEC_CMAX, default `c_ms(1000), clk cycles per one-second tick.
REQ-002 SHALL have parameter WAT_INIT, default 3, pre-run wait in seconds (0..59).
REQ-003 SHALL have parameter DONE_SECS, default 5, seconds the DONE state is held (1..59).
REQ-004 clk  input  1  single system clock, all state on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn_inc  input  1  one-cycle pulse, increments total setting.
REQ-007 btn_start  input  1  one-cycle pulse, start, resume or abort DONE.
REQ-008 btn_pause  input  1  one-cycle pulse, pause/resume toggle.
REQ-009 u_tot  output  6  configured total seconds, 1..59.
REQ-010 u_cur  output  6  elapsed run seconds, 0..u_tot.
REQ-011 u_wat  output  6  remaining wait seconds, 0..WAT_INIT.
REQ-012 fl_disp  output  1  display flash request.
REQ-013 done  output  1  high while in DONE.

Function
REQ-014 SHALL implement states IDLE, WAIT, RUN, PAUSE, DONE; all outputs registered, updating the cycle after the causing event.
REQ-015 SHALL generate tick internally: counter 0..SEC_CMAX-1, tick high one cycle at SEC_CMAX-1, counter cleared on every state change.
REQ-016 IDLE: btn_inc increments u_tot; 59 wraps to 1; u_cur=0, u_wat=0.
REQ-017 IDLE + btn_start: u_cur<=0; if WAT_INIT>0 go WAIT with u_wat<=WAT_INIT, else go RUN.
REQ-018 WAIT: on tick u_wat decrements; tick with u_wat==1 gives u_wat<=0 and RUN.
REQ-019 RUN: on tick u_cur increments; tick with u_cur==u_tot-1 gives u_cur<=u_tot and DONE.
REQ-020 btn_inc SHALL be ignored outside IDLE; u_tot never changes outside IDLE.
REQ-021 DONE: done=1, fl_disp=1; after DONE_SECS ticks go IDLE with u_cur<=0, u_tot retained; btn_start in DONE goes IDLE next cycle.
REQ-022 fl_disp SHALL be 0 in IDLE, WAIT, RUN; 1 in PAUSE and DONE.
REQ-023 Same-cycle priority: btn_start > btn_pause > btn_inc > tick; a tick coinciding with a button-caused transition is discarded.
REQ-024 btn_start in WAIT or RUN SHALL be ignored.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, u_tot=10, u_cur=0, u_wat=0, fl_disp=0, done=0, tick counter=0, including mid-WAIT/RUN/PAUSE/DONE.
REQ-026 First tick after reset release SHALL occur SEC_CMAX cycles after the first clk edge with rst_n high.

Configuration
REQ-027 Macro RUN_CTRL_PAUSE_EN defined: btn_pause in WAIT or RUN goes PAUSE, saving return state; PAUSE freezes u_cur, u_wat and the tick counter; btn_pause or btn_start returns to saved state with the tick counter cleared.
REQ-028 Macro RUN_CTRL_PAUSE_EN undefined: no PAUSE state or return-state register, btn_pause ignored in all states.

Verification (SEC_CMAX=4, WAT_INIT=3, DONE_SECS=5)
REQ-029 Reset, 50 btn_inc pulses -> u_tot steps 10..59 then wraps to 1, reaching 1 on the 50th pulse.
REQ-030 u_tot=2, btn_start -> u_wat 3,2,1,0 at 4-cycle ticks, RUN, u_cur 1,2, then DONE with done=1 and fl_disp=1 for 20 cycles, then IDLE, u_cur=0, u_tot=2.
REQ-031 btn_start and btn_inc same cycle in IDLE -> WAIT entered, u_tot unchanged.
REQ-032 RUN_CTRL_PAUSE_EN: pause at u_cur=1 for 40 cycles -> u_cur stays 1, fl_disp=1; resume -> next increment exactly 4 cycles later.
REQ-033 rst_n low mid-RUN (u_cur=5) -> same-edge-independent return to u_tot=10, u_cur=0, fl_disp=0, done=0.
REQ-034 btn_start in DONE -> IDLE next cycle, done=0, u_cur=0.

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl: timed run controller with a pre-run wait countdown, a run
// counter up to a configured total, and a held DONE phase.
// A one-second tick is derived internally from the system clock.
// Optional pause/resume support is enabled by defining RUN_CTRL_PAUSE_EN.
// Without it there is no PAUSE state and btn_pause has no effect.

`ifndef C_MS
// Milliseconds to clock cycles, assuming a 50 MHz system clock.
`define C_MS(ms) ((ms) * 50000)
`endif

module run_ctrl #(
   parameter int SEC_CMAX  = `C_MS(1000),
   parameter int WAT_INIT  = 3,
   parameter int DONE_SECS = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_inc,
   input  logic       btn_start,
   input  logic       btn_pause,
   output logic [5:0] u_tot,
   output logic [5:0] u_cur,
   output logic [5:0] u_wat,
   output logic       fl_disp,
   output logic       done
);

   localparam int              CNT_W     = (SEC_CMAX > 1) ? $clog2(SEC_CMAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEC_CMAX - 1);
   localparam logic [5:0]      WAT_VAL   = 6'(WAT_INIT);
   localparam logic [5:0]      DONE_LAST = 6'(DONE_SECS - 1);
   localparam logic [5:0]      TOT_RST   = 6'd10;
   localparam logic [5:0]      TOT_MAX   = 6'd59;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_RUN   = 3'd2,
      S_DONE  = 3'd3
`ifdef RUN_CTRL_PAUSE_EN
      ,
      S_PAUSE = 3'd4
`endif
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] tick_cnt_r;
   logic             tick_s;
   logic             freeze_s;
   logic [5:0]       u_tot_r;
   logic [5:0]       u_tot_nxt_s;
   logic [5:0]       u_cur_r;
   logic [5:0]       u_cur_nxt_s;
   logic [5:0]       u_wat_r;
   logic [5:0]       u_wat_nxt_s;
   logic [5:0]       done_cnt_r;
   logic [5:0]       done_cnt_nxt_s;
   logic             fl_disp_r;
   logic             fl_nxt_s;
   logic             done_r;
   logic             done_nxt_s;

`ifdef RUN_CTRL_PAUSE_EN
   state_t           ret_r;
   state_t           ret_nxt_s;
`else
   logic             unused_pause_s;
   assign unused_pause_s = btn_pause;
`endif

   // One-second tick: fires on the last count of the cycle counter.
   assign tick_s = (tick_cnt_r == CNT_LAST);

   // Next-state and datapath decisions; buttons outrank the tick, and a
   // button-caused transition swallows any coincident tick.
   always_comb begin
      state_nxt_s    = state_r;
      u_tot_nxt_s    = u_tot_r;
      u_cur_nxt_s    = u_cur_r;
      u_wat_nxt_s    = u_wat_r;
      done_cnt_nxt_s = done_cnt_r;
      freeze_s       = 1'b0;
`ifdef RUN_CTRL_PAUSE_EN
      ret_nxt_s      = ret_r;
`endif
      case (state_r)
         S_IDLE: begin
            if (btn_start) begin
               u_cur_nxt_s = 6'd0;
               if (WAT_INIT > 0) begin
                  state_nxt_s = S_WAIT;
                  u_wat_nxt_s = WAT_VAL;
               end else begin
                  state_nxt_s = S_RUN;
                  u_wat_nxt_s = 6'd0;
               end
            end else if (btn_inc) begin
               if (u_tot_r >= TOT_MAX) begin
                  u_tot_nxt_s = 6'd1;
               end else begin
                  u_tot_nxt_s = u_tot_r + 6'd1;
               end
            end else begin
               u_tot_nxt_s = u_tot_r;
            end
         end
         S_WAIT: begin
            if (tick_s) begin
               if (u_wat_r <= 6'd1) begin
                  u_wat_nxt_s = 6'd0;
                  state_nxt_s = S_RUN;
               end else begin
                  u_wat_nxt_s = u_wat_r - 6'd1;
               end
            end else begin
               u_wat_nxt_s = u_wat_r;
            end
         end
         S_RUN: begin
            if (tick_s) begin
               if ((u_cur_r + 6'd1) >= u_tot_r) begin
                  u_cur_nxt_s    = u_tot_r;
                  state_nxt_s    = S_DONE;
                  done_cnt_nxt_s = 6'd0;
               end else begin
                  u_cur_nxt_s = u_cur_r + 6'd1;
               end
            end else begin
               u_cur_nxt_s = u_cur_r;
            end
         end
         S_DONE: begin
            if (btn_start) begin
               state_nxt_s = S_IDLE;
               u_cur_nxt_s = 6'd0;
            end else if (tick_s) begin
               if (done_cnt_r >= DONE_LAST) begin
                  state_nxt_s = S_IDLE;
                  u_cur_nxt_s = 6'd0;
               end else begin
                  done_cnt_nxt_s = done_cnt_r + 6'd1;
               end
            end else begin
               done_cnt_nxt_s = done_cnt_r;
            end
         end
`ifdef RUN_CTRL_PAUSE_EN
         S_PAUSE: begin
            freeze_s = 1'b1;
            if (btn_start || btn_pause) begin
               state_nxt_s = ret_r;
            end else begin
               state_nxt_s = S_PAUSE;
            end
         end
`endif
         default: begin
            state_nxt_s = S_IDLE;
            u_cur_nxt_s = 6'd0;
            u_wat_nxt_s = 6'd0;
         end
      endcase
`ifdef RUN_CTRL_PAUSE_EN
      // Pause overrides any tick effect in WAIT/RUN and remembers where to go back.
      if (((state_r == S_WAIT) || (state_r == S_RUN)) && btn_pause) begin
         state_nxt_s    = S_PAUSE;
         ret_nxt_s      = state_r;
         u_cur_nxt_s    = u_cur_r;
         u_wat_nxt_s    = u_wat_r;
         done_cnt_nxt_s = done_cnt_r;
      end else begin
         ret_nxt_s = ret_nxt_s;
      end
`endif
   end

   // Output flags follow the state being entered so they line up with it.
   always_comb begin
      done_nxt_s = (state_nxt_s == S_DONE);
`ifdef RUN_CTRL_PAUSE_EN
      fl_nxt_s   = (state_nxt_s == S_DONE) || (state_nxt_s == S_PAUSE);
`else
      fl_nxt_s   = (state_nxt_s == S_DONE);
`endif
   end

   // Second counter: restarts on any state change, holds while paused.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_r <= '0;
      end else if (state_nxt_s != state_r) begin
         tick_cnt_r <= '0;
      end else if (freeze_s) begin
         tick_cnt_r <= tick_cnt_r;
      end else if (tick_s) begin
         tick_cnt_r <= '0;
      end else begin
         tick_cnt_r <= tick_cnt_r + CNT_W'(1);
      end
   end

   // State, datapath and registered output flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         u_tot_r    <= TOT_RST;
         u_cur_r    <= 6'd0;
         u_wat_r    <= 6'd0;
         done_cnt_r <= 6'd0;
         fl_disp_r  <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         u_tot_r    <= u_tot_nxt_s;
         u_cur_r    <= u_cur_nxt_s;
         u_wat_r    <= u_wat_nxt_s;
         done_cnt_r <= done_cnt_nxt_s;
         fl_disp_r  <= fl_nxt_s;
         done_r     <= done_nxt_s;
      end
   end

`ifdef RUN_CTRL_PAUSE_EN
   // Return target for a paused run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ret_r <= S_IDLE;
      end else begin
         ret_r <= ret_nxt_s;
      end
   end
`endif

   assign u_tot   = u_tot_r;
   assign u_cur   = u_cur_r;
   assign u_wat   = u_wat_r;
   assign fl_disp = fl_disp_r;
   assign done    = done_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Testbench for run_ctrl with SEC_CMAX=4, WAT_INIT=3, DONE_SECS=5.
// Compares the DUT against a mode/elapsed-time reference model.
module tb_run_ctrl;

   localparam int SEC_CMAX  = 4;
   localparam int WAT_INIT  = 3;
   localparam int DONE_SECS = 5;
`ifdef RUN_CTRL_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif
   localparam int M_IDLE = 0, M_WAIT = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

   logic       clk, rst_n, btn_inc, btn_start, btn_pause;
   logic [5:0] u_tot, u_cur, u_wat;
   logic       fl_disp, done;

   int checks = 0;
   int failures = 0;

   // Reference model: mode, settings, and cycles spent in the current mode.
   int m_mode, m_tot, m_cur, m_wat, m_age, m_dsec, m_ret;

   run_ctrl #(.SEC_CMAX(SEC_CMAX), .WAT_INIT(WAT_INIT), .DONE_SECS(DONE_SECS)) dut (
      .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_start(btn_start),
      .btn_pause(btn_pause), .u_tot(u_tot), .u_cur(u_cur), .u_wat(u_wat),
      .fl_disp(fl_disp), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_mode = M_IDLE; m_tot = 10; m_cur = 0; m_wat = 0;
      m_age = 0; m_dsec = 0; m_ret = M_IDLE;
   endtask

   function automatic logic exp_fl();
      return (m_mode == M_PAUSE) || (m_mode == M_DONE);
   endfunction

   function automatic logic exp_done();
      return (m_mode == M_DONE);
   endfunction

   // One clock of the reference: a second elapses every SEC_CMAX cycles in a mode.
   task automatic model_update(input bit i, input bit s, input bit p);
      bit tk;
      int prev;
      tk = ((m_age % SEC_CMAX) == (SEC_CMAX - 1));
      prev = m_mode;
      case (m_mode)
         M_IDLE: begin
            if (s) begin
               m_cur = 0;
               if (WAT_INIT > 0) begin m_mode = M_WAIT; m_wat = WAT_INIT; end
               else m_mode = M_RUN;
            end else if (i) begin
               m_tot = (m_tot == 59) ? 1 : m_tot + 1;
            end
         end
         M_WAIT: begin
            if (PAUSE_EN && p) begin m_ret = M_WAIT; m_mode = M_PAUSE; end
            else if (tk) begin
               m_wat = m_wat - 1;
               if (m_wat == 0) m_mode = M_RUN;
            end
         end
         M_RUN: begin
            if (PAUSE_EN && p) begin m_ret = M_RUN; m_mode = M_PAUSE; end
            else if (tk) begin
               m_cur = m_cur + 1;
               if (m_cur == m_tot) begin m_mode = M_DONE; m_dsec = 0; end
            end
         end
         M_PAUSE: begin
            if (s || p) m_mode = m_ret;
         end
         M_DONE: begin
            if (s) begin m_mode = M_IDLE; m_cur = 0; end
            else if (tk) begin
               m_dsec = m_dsec + 1;
               if (m_dsec == DONE_SECS) begin m_mode = M_IDLE; m_cur = 0; end
            end
         end
         default: m_mode = M_IDLE;
      endcase
      if (m_mode != prev) m_age = 0;
      else if (m_mode != M_PAUSE) m_age = m_age + 1;
   endtask

   task automatic step(input bit i, input bit s, input bit p);
      btn_inc = i; btn_start = s; btn_pause = p;
      @(posedge clk);
      model_update(i, s, p);
      #1;
      btn_inc = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
   endtask

   task automatic async_reset();
      #3 rst_n = 1'b0;
      #1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; btn_inc = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (u_tot !== 6'd10) begin failures++; $display("FAIL reset_u_tot actual=%0d expected=10", u_tot); end
      checks++; if (u_cur !== 6'd0) begin failures++; $display("FAIL reset_u_cur actual=%0d expected=0", u_cur); end
      checks++; if (u_wat !== 6'd0) begin failures++; $display("FAIL reset_u_wat actual=%0d expected=0", u_wat); end
      checks++; if (fl_disp !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL reset_flags fl_disp=%0b done=%0b expected=0/0", fl_disp, done);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_inc_wrap();
      int exp_tot;
      for (int k = 1; k <= 50; k++) begin
         step(1'b1, 1'b0, 1'b0);
         exp_tot = ((9 + k) % 59) + 1;
         checks++;
         if (u_tot !== 6'(exp_tot) || u_tot !== 6'(m_tot)) begin
            failures++; $display("FAIL inc_step k=%0d actual=%0d expected=%0d", k, u_tot, exp_tot);
         end
      end
      checks++; if (u_tot !== 6'd1) begin failures++; $display("FAIL inc_wrap_final actual=%0d expected=1", u_tot); end
      checks++; if (u_cur !== 6'd0 || u_wat !== 6'd0) begin
         failures++; $display("FAIL idle_counters u_cur=%0d u_wat=%0d expected=0/0", u_cur, u_wat);
      end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (u_tot !== 6'd2) begin failures++; $display("FAIL inc_to_two actual=%0d expected=2", u_tot); end
   endtask

   task automatic test_full_run();
      int cyc = 0, done_cycles = 0, bad_interval = 0, last_change = 0;
      logic [5:0] prev_wat;
      step(1'b0, 1'b1, 1'b0);
      checks++; if (u_wat !== 6'd3 || u_cur !== 6'd0 || done !== 1'b0) begin
         failures++; $display("FAIL start_wait u_wat=%0d u_cur=%0d done=%0b expected=3/0/0", u_wat, u_cur, done);
      end
      prev_wat = 6'd3;
      while (m_mode != M_IDLE && cyc < 200) begin
         step(1'b0, 1'b0, 1'b0);
         cyc++;
         checks++;
         if (u_tot !== 6'(m_tot) || u_cur !== 6'(m_cur) || u_wat !== 6'(m_wat) ||
             fl_disp !== exp_fl() || done !== exp_done()) begin
            failures++;
            $display("FAIL full_run cyc=%0d tot=%0d/%0d cur=%0d/%0d wat=%0d/%0d fl=%0b/%0b done=%0b/%0b",
                     cyc, u_tot, m_tot, u_cur, m_cur, u_wat, m_wat, fl_disp, exp_fl(), done, exp_done());
         end
         if (done === 1'b1) done_cycles++;
         if (u_wat !== prev_wat) begin
            if (cyc - last_change != SEC_CMAX) bad_interval++;
            last_change = cyc;
            prev_wat = u_wat;
         end
      end
      checks++; if (cyc != 40) begin failures++; $display("FAIL full_run_length actual=%0d expected=40", cyc); end
      checks++; if (done_cycles != 20) begin failures++; $display("FAIL done_hold actual=%0d expected=20", done_cycles); end
      checks++; if (bad_interval != 0) begin failures++; $display("FAIL wait_interval bad=%0d expected=0", bad_interval); end
      checks++; if (u_cur !== 6'd0 || u_tot !== 6'd2 || done !== 1'b0) begin
         failures++; $display("FAIL after_done u_cur=%0d u_tot=%0d done=%0b expected=0/2/0", u_cur, u_tot, done);
      end
   endtask

   task automatic test_start_inc_done_abort();
      int cyc = 0;
      bit pressed = 1'b0;
      step(1'b1, 1'b1, 1'b0);
      checks++; if (u_tot !== 6'd2 || u_wat !== 6'd3 || fl_disp !== 1'b0) begin
         failures++; $display("FAIL start_inc_same u_tot=%0d u_wat=%0d fl=%0b expected=2/3/0", u_tot, u_wat, fl_disp);
      end
      step(1'b0, 1'b1, 1'b0);
      checks++; if (u_wat !== 6'(m_wat) || u_tot !== 6'd2) begin
         failures++; $display("FAIL start_in_wait u_wat=%0d expected=%0d", u_wat, m_wat);
      end
      while (m_mode != M_DONE && cyc < 100) begin
         if (m_mode == M_RUN && !pressed) begin step(1'b1, 1'b1, 1'b0); pressed = 1'b1; end
         else step(1'b0, 1'b0, 1'b0);
         cyc++;
         checks++;
         if (u_tot !== 6'(m_tot) || u_cur !== 6'(m_cur) || u_wat !== 6'(m_wat) || done !== exp_done()) begin
            failures++; $display("FAIL to_done cyc=%0d cur=%0d/%0d wat=%0d/%0d tot=%0d/%0d", cyc, u_cur, m_cur, u_wat, m_wat, u_tot, m_tot);
         end
      end
      step(1'b0, 1'b0, 1'b0);
      checks++; if (done !== 1'b1 || fl_disp !== 1'b1 || u_cur !== 6'd2) begin
         failures++; $display("FAIL in_done done=%0b fl=%0b u_cur=%0d expected=1/1/2", done, fl_disp, u_cur);
      end
      step(1'b0, 1'b1, 1'b0);
      checks++; if (done !== 1'b0 || u_cur !== 6'd0 || fl_disp !== 1'b0 || u_tot !== 6'd2) begin
         failures++; $display("FAIL done_abort done=%0b u_cur=%0d fl=%0b u_tot=%0d expected=0/0/0/2", done, u_cur, fl_disp, u_tot);
      end
   endtask

   task automatic test_pause();
      int cyc = 0, bad = 0, n = 0;
      step(1'b0, 1'b1, 1'b0);
      while (m_cur != 1 && cyc < 100) begin step(1'b0, 1'b0, 1'b0); cyc++; end
      checks++; if (u_cur !== 6'd1) begin failures++; $display("FAIL pause_setup u_cur=%0d expected=1", u_cur); end
      step(1'b0, 1'b0, 1'b1);
      if (PAUSE_EN) begin
         checks++; if (fl_disp !== 1'b1) begin failures++; $display("FAIL pause_enter fl=%0b expected=1", fl_disp); end
         for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (u_cur !== 6'd1 || fl_disp !== 1'b1 || done !== 1'b0) bad++;
         end
         checks++; if (bad != 0) begin failures++; $display("FAIL pause_hold bad_cycles=%0d expected=0", bad); end
         step(1'b0, 1'b0, 1'b1);
         checks++; if (fl_disp !== 1'b0) begin failures++; $display("FAIL pause_resume fl=%0b expected=0", fl_disp); end
         while (u_cur === 6'd1 && n < 50) begin step(1'b0, 1'b0, 1'b0); n++; end
         checks++; if (n != SEC_CMAX) begin failures++; $display("FAIL resume_latency actual=%0d expected=%0d", n, SEC_CMAX); end
      end else begin
         checks++; if (fl_disp !== 1'b0 || u_cur !== 6'd1) begin
            failures++; $display("FAIL pause_ignored fl=%0b u_cur=%0d expected=0/1", fl_disp, u_cur);
         end
      end
      cyc = 0;
      while (m_mode != M_IDLE && cyc < 100) begin
         step(1'b0, 1'b0, 1'b0);
         cyc++;
         checks++;
         if (u_cur !== 6'(m_cur) || fl_disp !== exp_fl() || done !== exp_done()) begin
            failures++; $display("FAIL pause_tail cyc=%0d cur=%0d/%0d fl=%0b/%0b", cyc, u_cur, m_cur, fl_disp, exp_fl());
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int cyc = 0;
      async_reset();
      step(1'b0, 1'b1, 1'b0);
      while (m_cur != 5 && cyc < 200) begin step(1'b0, 1'b0, 1'b0); cyc++; end
      checks++; if (u_cur !== 6'd5 || u_tot !== 6'd10) begin
         failures++; $display("FAIL midrun_setup u_cur=%0d u_tot=%0d expected=5/10", u_cur, u_tot);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (u_tot !== 6'd10 || u_cur !== 6'd0 || u_wat !== 6'd0 || fl_disp !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL midrun_reset tot=%0d cur=%0d wat=%0d fl=%0b done=%0b expected=10/0/0/0/0",
                              u_tot, u_cur, u_wat, fl_disp, done);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_random();
      bit i, s, p;
      for (int c = 0; c < 800; c++) begin
         i = ($urandom_range(0, 7) == 0);
         s = ($urandom_range(0, 15) == 0);
         p = ($urandom_range(0, 19) == 0);
         step(i, s, p);
         checks++;
         if (u_tot !== 6'(m_tot) || u_cur !== 6'(m_cur) || u_wat !== 6'(m_wat) ||
             fl_disp !== exp_fl() || done !== exp_done()) begin
            failures++;
            $display("FAIL random cyc=%0d tot=%0d/%0d cur=%0d/%0d wat=%0d/%0d fl=%0b/%0b done=%0b/%0b",
                     c, u_tot, m_tot, u_cur, m_cur, u_wat, m_wat, fl_disp, exp_fl(), done, exp_done());
         end
      end
   endtask

   initial begin
      test_reset();
      test_inc_wrap();
      test_full_run();
      test_start_inc_done_abort();
      test_pause();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
